// File: rtl/macguffin_pkg.sv
// MacGuffin shared definitions: default sizes, word-slice positions, S-box tables with their
// input-bit selections, and the round-core state type.
package macguffin_pkg;

   localparam int unsigned DefBlockSize = 64;
   localparam int unsigned DefRoundNum  = 32;
   localparam int unsigned WordW        = DefBlockSize / 4;
   localparam int unsigned KeyW         = 3 * WordW;
   localparam int unsigned NumSbox      = 8;

   // Word positions inside a block: a is the most significant word.
   localparam int unsigned WordALsb = 3 * WordW;
   localparam int unsigned WordBLsb = 2 * WordW;
   localparam int unsigned WordCLsb = 1 * WordW;
   localparam int unsigned WordDLsb = 0;

   // Input bits per S-box: entries 0,1 index b, 2,3 index c, 4,5 index d.
   localparam int unsigned SboxSel [NumSbox][6] = '{
      '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15},
      '{12, 14, 1, 2, 4, 10}, '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5},
      '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
   };

   // DES S-boxes, row-major (entry = row*16 + col), entry 0 in the top nibble.
   localparam logic [255:0] SboxTable [NumSbox] = '{
      256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
      256'hF18E6B3497D2C05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
      256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
      256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
      256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
      256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
      256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
      256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
   };

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/macguffin_f.sv
// MacGuffin round function F. Purely combinational.
//   b_i, c_i, d_i : the three source words
//   k_i           : 48-bit round key, applied as {b,c,d} ^ k
//   f_o           : 16-bit result, S-box i drives bits [2i+1:2i]
module macguffin_f
   import macguffin_pkg::*;
(
   input  logic [WordW-1:0] b_i,
   input  logic [WordW-1:0] c_i,
   input  logic [WordW-1:0] d_i,
   input  logic [KeyW-1:0]  k_i,
   output logic [WordW-1:0] f_o
);

   logic [WordW-1:0] xb, xc, xd;

   assign xb = b_i ^ k_i[2*WordW +: WordW];
   assign xc = c_i ^ k_i[WordW +: WordW];
   assign xd = d_i ^ k_i[0 +: WordW];

   for (genvar i = 0; i < NumSbox; i++) begin : g_sbox
      logic [5:0] idx;
      logic [3:0] nib;
      // DES addressing: row = {x5,x0}, col = x4..x1, so idx = {x5,x0,x4,x3,x2,x1}.
      assign idx = {xb[SboxSel[i][0]], xd[SboxSel[i][5]], xb[SboxSel[i][1]],
                    xc[SboxSel[i][2]], xc[SboxSel[i][3]], xd[SboxSel[i][4]]};
      assign nib = SboxTable[i][(63 - int'(idx)) * 4 +: 4];
      // Only the two outer output bits of each DES S-box are kept.
      assign f_o[2*i +: 2] = {nib[3], nib[0]};
   end

endmodule

// File: rtl/macguffin_round_core.sv
// Iterative MacGuffin round core, one round per clock, AXI-Stream in and out.
//   clk, rst_n            : clock, synchronous active-low reset
//   s_axis_*              : input block, tuser 0 = encrypt / 1 = decrypt
//   m_axis_*              : output block, held until accepted
//   round_keys            : round-key array, must be stable while busy
//   busy                  : high in RUN and DONE
module macguffin_round_core
   import macguffin_pkg::*;
#(
   parameter int unsigned RoundNum  = DefRoundNum,
   parameter int unsigned BlockSize = DefBlockSize
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [BlockSize-1:0]               s_axis_tdata,
   input  logic                               s_axis_tuser,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   output logic [BlockSize-1:0]               m_axis_tdata,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   input  logic [RoundNum-1:0][KeyW-1:0]      round_keys,
   output logic                               busy
);

   localparam int unsigned CntW = $clog2(RoundNum);

   state_e               state_q, state_d;
   logic [BlockSize-1:0] data_q, data_d;
   logic                 mode_q, mode_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [CntW-1:0]      key_idx;
   logic [KeyW-1:0]      key;
   logic [WordW-1:0]     wa, wb, wc, wd;
   logic [WordW-1:0]     fb, fc, fd, f_res;

   assign wa = data_q[WordALsb +: WordW];
   assign wb = data_q[WordBLsb +: WordW];
   assign wc = data_q[WordCLsb +: WordW];
   assign wd = data_q[WordDLsb +: WordW];

   // Decrypt rotates before applying F, so F sees the pre-rotation a,b,c.
   assign fb = mode_q ? wa : wb;
   assign fc = mode_q ? wb : wc;
   assign fd = mode_q ? wc : wd;

   assign key_idx = mode_q ? (CntW'(RoundNum - 1) - cnt_q) : cnt_q;
   assign key     = round_keys[key_idx];

   macguffin_f u_f (
      .b_i (fb),
      .c_i (fc),
      .d_i (fd),
      .k_i (key),
      .f_o (f_res)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (s_axis_tvalid) begin
               data_d  = s_axis_tdata;
               mode_d  = s_axis_tuser;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            data_d = mode_q ? {wd ^ f_res, wa, wb, wc} : {wb, wc, wd, wa ^ f_res};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CntW'(RoundNum - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (m_axis_tready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   // All handshake outputs decode the state register only.
   assign s_axis_tready = (state_q == StIdle);
   assign m_axis_tvalid = (state_q == StDone);
   assign m_axis_tdata  = m_axis_tvalid ? data_q : '0;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_macguffin_round_core.sv
module tb_macguffin_round_core;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [63:0]         s_axis_tdata;
   logic                s_axis_tuser;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic [63:0]         m_axis_tdata;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic [31:0][47:0]   round_keys;
   logic                busy;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int n_hs = 0;
   int n_out = 0;
   logic [63:0] last_out = '0;
   logic [63:0] sb [$];

   always #5 clk = ~clk;

   macguffin_round_core dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .round_keys    (round_keys),
      .busy          (busy)
   );

   // Reference tables, one 64-bit word per DES S-box row, column 0 in the top nibble.
   logic [63:0] tb_sbox [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B3497D2C05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };
   int tb_sel [8][6] = '{
      '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15},
      '{12, 14, 1, 2, 4, 10}, '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5},
      '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
   };

   function automatic logic [15:0] m_f(logic [15:0] b, logic [15:0] c, logic [15:0] d,
                                       logic [47:0] k);
      logic [15:0] xb, xc, xd, r;
      logic [63:0] rowv;
      logic [3:0]  v;
      int          row, col;
      xb = b ^ k[47:32];
      xc = c ^ k[31:16];
      xd = d ^ k[15:0];
      r  = '0;
      for (int s = 0; s < 8; s++) begin
         row  = 2 * int'(xb[tb_sel[s][0]]) + int'(xd[tb_sel[s][5]]);
         col  = 8 * int'(xb[tb_sel[s][1]]) + 4 * int'(xc[tb_sel[s][2]])
              + 2 * int'(xc[tb_sel[s][3]]) + int'(xd[tb_sel[s][4]]);
         rowv = tb_sbox[s][row];
         v    = rowv[(15 - col) * 4 +: 4];
         r[2*s+1] = v[3];
         r[2*s]   = v[0];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_cipher(logic [63:0] blk, logic dec);
      logic [15:0] a, b, c, d, t;
      {a, b, c, d} = blk;
      for (int r = 0; r < 32; r++) begin
         if (!dec) begin
            t = a ^ m_f(b, c, d, round_keys[r]);
            a = b; b = c; c = d; d = t;
         end else begin
            t = d; d = c; c = b; b = a; a = t;
            a = a ^ m_f(b, c, d, round_keys[31 - r]);
         end
      end
      return {a, b, c, d};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard push on every accepted input; a reset discards whatever was in flight.
   always @(posedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else if (s_axis_tvalid && s_axis_tready) begin
         sb.push_back(m_cipher(s_axis_tdata, s_axis_tuser));
         hs_cyc = cyc;
         n_hs++;
      end
      cyc = cyc + 1;
   end

   // Monitor.
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [63:0] prev_data  = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (m_axis_tvalid) begin
            if (!prev_valid) check("latency", 64'(cyc - hs_cyc), 64'd33);
            if (prev_valid && !prev_ready) check("hold_data", m_axis_tdata, prev_data);
            check("blocked_in", {s_axis_tready, busy}, 64'b01);
            if (m_axis_tready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 64'd1, 64'd0);
               end else begin
                  check("out_data", m_axis_tdata, sb.pop_front());
               end
               last_out = m_axis_tdata;
               n_out++;
            end
         end
         prev_valid = m_axis_tvalid;
         prev_ready = m_axis_tready;
         prev_data  = m_axis_tdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] data, input logic user);
      int n = 0;
      while (!s_axis_tready && n < 200) begin
         tick(1);
         n++;
      end
      if (!s_axis_tready) check("tready_timeout", 64'd0, 64'd1);
      s_axis_tdata  = data;
      s_axis_tuser  = user;
      s_axis_tvalid = 1'b1;
      tick(1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_out(input int target);
      int n = 0;
      while (n_out < target && n < 200) begin
         tick(1);
         n++;
      end
      if (n_out < target) check("out_timeout", 64'(n_out), 64'(target));
   endtask

   task automatic set_keys(input logic [63:0] seed);
      for (int i = 0; i < 32; i++) begin
         round_keys[i] = 48'((64'h9E3779B97F4A7C15 * 64'(i + 1)) ^ seed);
      end
   endtask

   logic [63:0] ct;
   int          hs_snap;
   int          out_snap;

   initial begin
      rst_n         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tuser  = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      round_keys    = '0;
      tick(3);
      check("rst_tready", 64'(s_axis_tready), 64'd1);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick(1);

      // Known-answer blocks: all-zero keys, then a fixed key set.
      send(64'h0, 1'b0);
      wait_out(1);
      set_keys(64'h0);
      send(64'h0, 1'b0);
      wait_out(2);
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      wait_out(3);

      // Round trip with a different key set.
      set_keys(64'h0123_4567_89AB_CDEF);
      send(64'h0123_4567_89AB_CDEF, 1'b0);
      wait_out(4);
      ct = last_out;
      check("ct_differs", 64'(ct != 64'h0123_4567_89AB_CDEF), 64'd1);
      send(ct, 1'b1);
      wait_out(5);
      check("round_trip", last_out, 64'h0123_4567_89AB_CDEF);

      // Backpressure in DONE with a pending input held valid.
      m_axis_tready = 1'b0;
      send(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      for (int n = 0; n < 100 && !m_axis_tvalid; n++) tick(1);
      check("bp_valid", 64'(m_axis_tvalid), 64'd1);
      s_axis_tdata  = 64'h1122_3344_5566_7788;
      s_axis_tuser  = 1'b0;
      s_axis_tvalid = 1'b1;
      hs_snap = n_hs;
      tick(10);
      check("bp_no_accept", 64'(n_hs), 64'(hs_snap));
      check("bp_still_valid", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      tick(1);
      check("bp_release", {m_axis_tvalid, s_axis_tready}, 64'b01);
      tick(1);
      s_axis_tvalid = 1'b0;
      check("bp_next_accept", 64'(n_hs), 64'(hs_snap + 1));
      wait_out(7);

      // Reset mid-block: nothing comes out, then a fresh block works.
      send(64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
      tick(15);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("midrst_idle", {s_axis_tready, busy, m_axis_tvalid}, 64'b100);
      out_snap = n_out;
      tick(40);
      check("midrst_no_out", 64'(n_out), 64'(out_snap));
      send(64'h0F1E_2D3C_4B5A_6978, 1'b1);
      wait_out(out_snap + 1);
      tick(2);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/macguffin_round_core.md
Name: macguffin_round_core

Overview:
- Iterative MacGuffin block-cipher datapath, one round per clock, with AXI-Stream input and output.
- Sits next to key_setup. During key expansion it receives key_setup's m_axis blocks and returns results on key_setup's s_axis. After expansion it serves normal encrypt/decrypt traffic.
- Reads the round-key array combinationally. The array must be stable while a block is in flight.

Parameters:
- round_num, 32, number of rounds; power of two; counter width $clog2(round_num)
- block_size, 64, block width; four words of block_size/4 bits each
- key_w, block_size*3/4, width of one round key (48)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  block_size  input block
- s_axis_tuser  in  1  0 = encrypt, 1 = decrypt
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  block_size  output block
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- round_keys  in  key_w x round_num  round-key array, indexed 0..round_num-1
- busy  out  1  high while a block is held or processed (states RUN and DONE)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; s_axis_tready=1; m_axis_tvalid=0; m_axis_tdata=0; busy=0; counter=0.
  - Reset dominates every other event, including a reset in RUN or DONE. The in-flight block is discarded and no output is produced.
- Word split: a=[63:48], b=[47:32], c=[31:16], d=[15:0].
- F(b,c,d,k):
  - Computed on {b,c,d} XOR k.
  - Eight 6-in/2-out S-boxes, with bit selection and tables per the MacGuffin definition.
  - Produces a 16-bit result.
- Encrypt round r (r = 0..round_num-1):
  - a' = a XOR F(b,c,d,K[r])
  - next state {b,c,d,a'}
- Decrypt round:
  - rotate first: {a,b,c,d} <= {d,a,b,c}
  - then a ^= F(b,c,d,K[r]), with r descending from round_num-1 to 0.
- FSM states:
  - IDLE: s_axis_tready=1. On tvalid&&tready: latch tdata into the state register, latch tuser into the mode flag, set counter=0, go to RUN.
  - RUN: s_axis_tready=0. Execute one round per cycle. The key index is counter (encrypt) or round_num-1-counter (decrypt). Counter increments. After the round with counter=round_num-1, go to DONE.
  - DONE: m_axis_tvalid=1; m_axis_tdata = the state register.
    - m_axis_tvalid and m_axis_tdata are held constant until m_axis_tready=1.
    - On the handshake, go to IDLE next cycle. m_axis_tvalid falls and s_axis_tready rises in that same cycle.
- Latency:
  - The input handshake occurs at cycle 0.
  - m_axis_tvalid is first high at cycle round_num+1 (33).
  - Minimum initiation interval is round_num+2 cycles.
- Simultaneous events and boundaries:
  - s_axis_tvalid in RUN or DONE is ignored; tready=0 throughout.
  - Counter wrap after the last round is permitted: the counter is don't-care outside RUN.
  - s_axis_tuser is sampled only at the input handshake.
  - m_axis_tready while m_axis_tvalid=0 has no effect.
- No combinational path from m_axis_tready to s_axis_tready. Both are registered outputs derived from state.

Decomposition:
- macguffin_pkg:
  - block_size/round_num defaults and word-slice constants
  - S-box tables as localparam arrays, with their input-bit selection constants
  - state enum typedef (IDLE, RUN, DONE)
- Sub-module macguffin_f:
  - purely combinational F function: (b,c,d,k) -> 16-bit result
  - shared with future pipelined variants

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, busy=0.
- Known-answer:
  - Stimulus: round_keys from the software reference model for key 0x00000000000000000000000000000000, encrypt 0x0000000000000000.
  - Required: m_axis_tdata equals the model output; first m_axis_tvalid exactly 33 cycles after the input handshake.
- Round trip: encrypt 0x0123456789ABCDEF with fixed random keys; feed the result back with tuser=1 -> output equals 0x0123456789ABCDEF.
- Backpressure and input blocking:
  - Stimulus: m_axis_tready=0 for 10 cycles in DONE, with s_axis_tvalid held at 1 throughout.
  - Required: tdata stable; tvalid stays 1; no second input accepted. tready=1 -> IDLE next cycle, then the next block is accepted.
- Reset mid-operation: pulse rst_n=0 at round 15 -> IDLE; no m_axis_tvalid. A following block produces the correct result.
- Key-setup integration: connect to key_setup, run 1000 random 128-bit keys -> key_ready rises; round_keys match the software model for each key.
